// File: rtl/bsm_pkg.sv
// Shared types for the bit-serial multiplier dispatcher.
// Holds the FSM state enum, datapath widths and the command bundle.
package bsm_pkg;

    localparam int BSM_DATA_W  = 32;
    localparam int BSM_WIDTH_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        CAPTURE,
        OUT
    } bsm_disp_state_e;

    // The tag width is a module parameter, so the tag travels
    // beside this struct rather than inside it.
    typedef struct packed {
        logic [BSM_WIDTH_W-1:0] wa;
        logic [BSM_WIDTH_W-1:0] wb;
        logic [BSM_DATA_W-1:0]  a;
        logic [BSM_DATA_W-1:0]  b;
    } bsm_cmd_t;

    function automatic logic bsm_width_ok(
        input logic [BSM_WIDTH_W-1:0] wa,
        input logic [BSM_WIDTH_W-1:0] wb
    );
        return (wa != '0) && (wb != '0);
    endfunction

endpackage

// File: rtl/bsm_cmd_fifo.sv
// Synchronous command FIFO feeding the dispatcher FSM.
// Ports: clk, rst (async, active-high); push/push_cmd/push_tag write;
//        pop advances head_cmd/head_tag; full/empty from the
//        registered occupancy count. Push is dropped when full.
module bsm_cmd_fifo
    import bsm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  bsm_cmd_t         push_cmd,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output bsm_cmd_t         head_cmd,
    output logic [TAG_W-1:0] head_tag,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    bsm_cmd_t         cmd_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // No bypass: a full FIFO refuses a push even if it pops too.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_cmd = cmd_mem[rd_ptr];
    assign head_tag = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            cmd_mem[wr_ptr] <= push_cmd;
            tag_mem[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/bsm_dispatch.sv
// Command sequencer in front of the bit-serial multiplier: buffers
// multiply commands, runs them one at a time, returns tagged products.
// Ports: clk, rst (async, active-high)
//   cmd_*  : valid/ready command stream (wa, wb, a, b, tag)
//   mul_*  : start pulse, held operands, done/product from multiplier
//   res_*  : valid/ready result stream (data, tag, err)
// Optional: define BSM_DISP_TIMEOUT_EN for a RUN-state watchdog.
module bsm_dispatch
    import bsm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BSM_WIDTH_W-1:0] cmd_wa,
    input  logic [BSM_WIDTH_W-1:0] cmd_wb,
    input  logic [BSM_DATA_W-1:0]  cmd_a,
    input  logic [BSM_DATA_W-1:0]  cmd_b,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   mul_start,
    output logic [BSM_WIDTH_W-1:0] mul_wa,
    output logic [BSM_WIDTH_W-1:0] mul_wb,
    output logic [BSM_DATA_W-1:0]  mul_a,
    output logic [BSM_DATA_W-1:0]  mul_b,
    input  logic                   mul_done,
    input  logic [BSM_DATA_W-1:0]  mul_o,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [BSM_DATA_W-1:0]  res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_err
);

    bsm_disp_state_e  state;
    bsm_disp_state_e  state_nxt;

    bsm_cmd_t         push_cmd;
    bsm_cmd_t         head_cmd;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] tag_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    logic             ld_bad;
    logic             ld_cap;

    assign cmd_ready   = !fifo_full;
    assign push_cmd.wa = cmd_wa;
    assign push_cmd.wb = cmd_wb;
    assign push_cmd.a  = cmd_a;
    assign push_cmd.b  = cmd_b;

    bsm_cmd_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid),
        .push_cmd (push_cmd),
        .push_tag (cmd_tag),
        .pop      (fifo_pop),
        .head_cmd (head_cmd),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef BSM_DISP_TIMEOUT_EN
    logic [9:0] wd_cnt;
    logic [9:0] wd_limit;
    logic       wd_hit;
    logic       ld_tmo;

    // Limit is three cycles beyond the expected done slot.
    assign wd_limit = 10'(mul_wa) * 10'(mul_wb) + 10'd4;
    assign wd_hit   = (wd_cnt + 10'd1) == wd_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 10'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        mul_start = 1'b0;
        res_valid = 1'b0;
        ld_bad    = 1'b0;
        ld_cap    = 1'b0;
`ifdef BSM_DISP_TIMEOUT_EN
        ld_tmo    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (bsm_width_ok(head_cmd.wa, head_cmd.wb)) begin
                        state_nxt = LAUNCH;
                    end else begin
                        ld_bad    = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
            LAUNCH: begin
                mul_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (mul_done) begin
                    state_nxt = CAPTURE;
`ifdef BSM_DISP_TIMEOUT_EN
                end else if (wd_hit) begin
                    ld_tmo    = 1'b1;
                    state_nxt = OUT;
`endif
                end
            end
            CAPTURE: begin
                ld_cap    = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands move only on a pop, so they stay put for the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_wa <= '0;
            mul_wb <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            tag_q  <= '0;
        end else if (fifo_pop) begin
            mul_wa <= head_cmd.wa;
            mul_wb <= head_cmd.wb;
            mul_a  <= head_cmd.a;
            mul_b  <= head_cmd.b;
            tag_q  <= head_tag;
        end
    end

    // Result registers load only on the way into OUT, never while
    // OUT is waiting, which keeps them stable across a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_tag  <= '0;
            res_err  <= 1'b0;
        end else begin
            if (ld_bad) begin
                res_data <= '0;
                res_tag  <= head_tag;
                res_err  <= 1'b1;
            end
            if (ld_cap) begin
                res_data <= mul_o;
                res_tag  <= tag_q;
                res_err  <= 1'b0;
            end
`ifdef BSM_DISP_TIMEOUT_EN
            if (ld_tmo) begin
                res_data <= '0;
                res_tag  <= tag_q;
                res_err  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bsm_dispatch.sv
// Scoreboard bench for bsm_dispatch with a behavioural multiplier.
// Expected results are queued at issue; a monitor checks on output.
module tb_bsm_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_wa = '0;
    logic [4:0]  cmd_wb = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic        mul_start;
    logic [4:0]  mul_wa;
    logic [4:0]  mul_wb;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_o = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;

    bsm_dispatch #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wa    (cmd_wa),
        .cmd_wb    (cmd_wb),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .mul_start (mul_start),
        .mul_wa    (mul_wa),
        .mul_wb    (mul_wb),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_o     (mul_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q[$];

    task automatic expect_res(input logic [31:0] d, input logic [3:0] t,
                              input logic e, input int lat);
        exp_t x;
        x.data = d;
        x.tag  = t;
        x.err  = e;
        x.lat  = lat;
        q.push_back(x);
    endtask

    // Behavioural multiplier: done in cycle N+1 after the start
    // edge, product only in cycle N+2, junk on mul_o otherwise.
    logic        m_pend = 1'b0;
    logic        m_hang = 1'b0;
    logic        m_chk = 1'b0;
    int          m_s = 0;
    int          m_n = 0;
    int          starts = 0;
    logic [31:0] m_prod;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_wa;
    logic [4:0]  m_wb;

    function automatic logic [31:0] sext(input logic [31:0] v,
                                         input logic [4:0] w);
        logic [31:0] r;
        r = v << (32 - w);
        return $signed(r) >>> (32 - w);
    endfunction

    always @(negedge clk) begin
        int k;
        mul_done = 1'b0;
        mul_o    = 32'hdeadbeef;
        if (rst) m_chk = 1'b0;
        if (m_pend) begin
            k = cyc - m_s + 1;
            if (k == m_n + 1) begin
                if (!m_hang) mul_done = 1'b1;
                if (m_chk)
                    chk("operands_held",
                        {31'd0, mul_a == m_a && mul_b == m_b &&
                         mul_wa == m_wa && mul_wb == m_wb}, 32'd1);
            end
            if (k == m_n + 2) begin
                if (!m_hang) mul_o = m_prod;
                m_pend = 1'b0;
            end
        end
        if (mul_start) begin
            starts++;
            m_pend = 1'b1;
            m_chk  = 1'b1;
            m_s    = cyc + 1;
            m_wa   = mul_wa;
            m_wb   = mul_wb;
            m_a    = mul_a;
            m_b    = mul_b;
            m_n    = int'(mul_wa) * int'(mul_wb);
            m_prod = $signed(sext(mul_a, mul_wa)) *
                     $signed(sext(mul_b, mul_wb));
        end
    end

    // Monitor: samples just after the falling edge.
    logic        pv = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] sd;
    logic [3:0]  st;
    logic        se;
    int          lat_seen = 0;

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (res_valid && !pv) begin
            lat_seen = cyc - m_s + 1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got tag %0d data %h, required none",
                         res_tag, res_data);
            end
        end
        if (stall && res_valid) begin
            chk("stall_data", res_data, sd);
            chk("stall_tag", {28'd0, res_tag}, {28'd0, st});
            chk("stall_err", {31'd0, res_err}, {31'd0, se});
        end
        if (res_valid && res_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_tag", {28'd0, res_tag}, {28'd0, e.tag});
            chk("res_err", {31'd0, res_err}, {31'd0, e.err});
            if (e.lat > 0) chk("latency", lat_seen, e.lat);
        end
        stall = res_valid && !res_ready;
        sd    = res_data;
        st    = res_tag;
        se    = res_err;
        pv    = res_valid;
    end

    // Called at a falling edge; returns at the falling edge after
    // acceptance so successive calls stream back-to-back.
    task automatic push(input logic [4:0] wa, input logic [4:0] wb,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_wa    = wa;
        cmd_wb    = wb;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: tag %0d not accepted, cmd_ready %b required 1",
                     tag, cmd_ready);
        end else begin
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0",
                     q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
        chk("rst_mul_wa", {27'd0, mul_wa}, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", {28'd0, res_tag}, 32'd0);
        chk("rst_res_err", {31'd0, res_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 5 * -3 in 4-bit operands
        s0 = starts;
        expect_res(32'hFFFFFFF1, 4'd3, 1'b0, 19);
        push(5'd4, 5'd4, 32'd5, 32'hD, 4'd3);
        drain(100);
        chk("single_starts", starts - s0, 32'd1);

        // zero width: error result, multiplier untouched
        s0 = starts;
        expect_res(32'd0, 4'd7, 1'b1, 0);
        push(5'd0, 5'd8, 32'h12, 32'h34, 4'd7);
        drain(50);
        chk("illegal_starts", starts - s0, 32'd0);

        // -1 * -2^30
        expect_res(32'h40000000, 4'd2, 1'b0, 34);
        push(5'd1, 5'd31, 32'd1, 32'h40000000, 4'd2);
        drain(100);

        // fill with results stalled
        res_ready = 1'b0;
        expect_res(32'd1, 4'd0, 1'b0, 0);
        expect_res(32'hFFFFFFFF, 4'd1, 1'b0, 0);
        expect_res(32'd4, 4'd2, 1'b0, 0);
        expect_res(32'hFFFFFFFE, 4'd3, 1'b0, 0);
        expect_res(32'd1, 4'd4, 1'b0, 0);
        push(5'd2, 5'd2, 32'h5, 32'h1, 4'd0);
        push(5'd2, 5'd2, 32'h3, 32'h1, 4'd1);
        push(5'd2, 5'd2, 32'h2, 32'h2, 4'd2);
        push(5'd2, 5'd2, 32'h1, 32'h2, 4'd3);
        push(5'd2, 5'd2, 32'h3, 32'h3, 4'd4);
        chk("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (12) @(negedge clk);
        chk("fill_cmd_ready_held", {31'd0, cmd_ready}, 32'd0);
        res_ready = 1'b1;
        drain(300);
        chk("fill_drained_ready", {31'd0, cmd_ready}, 32'd1);

        // reset five cycles into a run with a second command queued
        push(5'd4, 5'd4, 32'd3, 32'd3, 4'd9);
        push(5'd2, 5'd2, 32'd1, 32'd1, 4'd10);
        n = 0;
        while (starts == s0 + 6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        s0 = starts;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_mul_a", mul_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("postrst_no_result", {31'd0, res_valid}, 32'd0);
        chk("postrst_no_start", starts - s0, 32'd0);
        expect_res(32'd1, 4'd5, 1'b0, 7);
        push(5'd2, 5'd2, 32'd1, 32'd1, 4'd5);
        drain(100);

        // multiplier never answers
        m_hang = 1'b1;
`ifdef BSM_DISP_TIMEOUT_EN
        expect_res(32'd0, 4'd11, 1'b1, 14);
        push(5'd3, 5'd3, 32'd2, 32'd2, 4'd11);
        drain(100);
`else
        push(5'd3, 5'd3, 32'd2, 32'd2, 4'd11);
        repeat (40) @(negedge clk);
        chk("hang_no_result", {31'd0, res_valid}, 32'd0);
        pulse_reset();
`endif
        m_hang = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

endmodule
